wb_pipe_reg: RTL

WB_PIPE_REG -- requirements
Module: wb_pipe_reg

---
 rtl/wb_pipe_pkg.sv | 10 +
 rtl/wb_pipe_slot.sv | 36 +++
 rtl/wb_pipe_reg.sv | 103 ++++++++++
 3 files changed

// File: rtl/wb_pipe_pkg.sv
// rtl/wb_pipe_pkg.sv - shared widths and occupancy-width helper for the writeback pipe register
package wb_pipe_pkg;
    localparam int WB_DATA_W     = 32;
    localparam int WB_MAX_STAGES = 8;

    // Bits needed to count 0..n live slots.
    function automatic int wb_occ_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/wb_pipe_slot.sv
// rtl/wb_pipe_slot.sv - one pipe slot: valid bit plus payload register with load/hold/clear
module wb_pipe_slot
    import wb_pipe_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Clear kills only the valid bit; payload is captured only for live entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - bubble-collapsing writeback pipe register; optional stats via WB_PIPE_STATS_EN
module wb_pipe_reg
    import wb_pipe_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int NUM_STAGES = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_W-1:0]                   in_data,
    input  logic                                flush,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_W-1:0]                   out_data,
    output logic [wb_occ_w(NUM_STAGES)-1:0]     occupancy
`ifdef WB_PIPE_STATS_EN
    ,
    output logic [31:0]                         stall_cnt,
    output logic [31:0]                         xfer_cnt
`endif
);
    localparam int OCC_W = wb_occ_w(NUM_STAGES);

    logic [NUM_STAGES-1:0] w_valid;
    logic [NUM_STAGES-1:0] w_open;
    logic [DATA_W-1:0]     w_data [NUM_STAGES];
    logic                  w_head_xfer;
    logic [OCC_W-1:0]      w_occ;

    assign out_valid   = w_valid[NUM_STAGES-1] && !flush;
    assign out_data    = w_data[NUM_STAGES-1];
    assign w_head_xfer = out_valid && out_ready;

    // A slot can load when it is empty or its entry moves on; evaluated from head back to slot 0.
    always_comb begin
        w_open = '0;
        w_open[NUM_STAGES-1] = !w_valid[NUM_STAGES-1] || w_head_xfer;
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            w_open[i] = !w_valid[i] || w_open[i+1];
        end
    end

    assign in_ready = !flush && w_open[0];

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_slot
        logic              w_src_valid;
        logic [DATA_W-1:0] w_src_data;

        if (g == 0) begin : g_first
            assign w_src_valid = in_valid;
            assign w_src_data  = in_data;
        end else begin : g_next
            assign w_src_valid = w_valid[g-1];
            assign w_src_data  = w_data[g-1];
        end

        wb_pipe_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clear (flush),
            .i_load  (w_open[g]),
            .i_valid (w_src_valid),
            .i_data  (w_src_data),
            .o_valid (w_valid[g]),
            .o_data  (w_data[g])
        );
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_occ = w_occ + OCC_W'(w_valid[i]);
        end
    end

    assign occupancy = w_occ;

`ifdef WB_PIPE_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_xfer_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_head_xfer && (r_xfer_cnt != 32'hFFFF_FFFF)) begin
                r_xfer_cnt <= r_xfer_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign xfer_cnt  = r_xfer_cnt;
`endif
endmodule
